// File: rtl/fsmd_pkg.sv
// fsmd_pkg: shared state codes and width helper for the scheduled datapath
package fsmd_pkg;
    localparam int STATE_W = 3;
    typedef enum logic [STATE_W-1:0] {
        IDLE = 3'd0,
        S1   = 3'd1,
        S2   = 3'd2,
        S3   = 3'd3,
        S4   = 3'd4,
        DONE = 3'd5
    } state_t;
    function automatic int full_width(input int w);
        return 2 * w + 3;
    endfunction
endpackage

// File: rtl/fsmd_sched_ctrl.sv
// fsmd_sched_ctrl: schedule sequencer with busy/done decode
module fsmd_sched_ctrl
    import fsmd_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    output logic [STATE_W-1:0] state,
    output logic               busy,
    output logic               done
);
    logic [STATE_W-1:0] state_d, state_q;
    logic               busy_d, busy_q;
    // walk the fixed schedule; unused codes fall back to IDLE
    always_comb begin
        state_d = state_q == IDLE ? (start ? S1 : IDLE) :
                  state_q == S1   ? S2 :
                  state_q == S2   ? S3 :
                  state_q == S3   ? S4 :
                  state_q == S4   ? DONE : IDLE;
        busy_d  = state_d != IDLE;
    end
    // state and registered busy flag
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
        end
    end
    assign state = state_q;
    assign busy  = busy_q;
    assign done  = state_q == DONE;
endmodule

// File: rtl/fsmd_sched_dp.sv
// fsmd_sched_dp: computes (a+b+c)*e and (a+b+c)*(c+d) over a fixed schedule
module fsmd_sched_dp
    import fsmd_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int RW    = 2 * WIDTH + 3
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               acc,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [WIDTH-1:0]   c,
    input  logic [WIDTH-1:0]   d,
    input  logic [WIDTH-1:0]   e,
    output logic               busy,
    output logic               done,
    output logic [RW-1:0]      y1,
    output logic [RW-1:0]      y2,
    output logic               ovf,
    output logic [STATE_W-1:0] state
);
    localparam int FW = full_width(WIDTH);
    localparam int RD = WIDTH + 2;
    logic [STATE_W-1:0] st;
    logic               go;
    logic [RD-1:0]      r1_d, r1_q, r2_d, r2_q, r3_d, r3_q;
    logic [WIDTH-1:0]   b_d, b_q, d_d, d_q, e_d, e_q;
    logic               acc_d, acc_q, ovf_d, ovf_q;
    logic [RW-1:0]      y1_d, y1_q, y2_d, y2_q;
    logic [FW-1:0]      p1, p2;
    logic [RW:0]        acc_sum;

    fsmd_sched_ctrl u_ctrl (
        .clock (clock),
        .reset (reset),
        .start (start),
        .state (st),
        .busy  (busy),
        .done  (done)
    );

    assign go = st == IDLE && start;

    // schedule the working registers and form the S4 results
    always_comb begin
        p1      = FW'(r1_q) * FW'(r3_q);
        p2      = FW'(r1_q) * FW'(r2_q);
        acc_sum = {1'b0, y1_q} + {1'b0, p1[RW-1:0]};
        r1_d    = go ? {2'b0, a} : st == S1 ? r1_q + r2_q : st == S3 ? r1_q + r3_q : r1_q;
        r2_d    = go ? {2'b0, c} : st == S2 ? r2_q + r3_q : r2_q;
        r3_d    = st == S1 ? {2'b0, d_q} : st == S2 ? {2'b0, b_q} : st == S3 ? {2'b0, e_q} : r3_q;
        b_d     = go ? b : b_q;
        d_d     = go ? d : d_q;
        e_d     = go ? e : e_q;
        acc_d   = go ? acc : acc_q;
        y1_d    = st == S4 ? (acc_q ? acc_sum[RW-1:0] : p1[RW-1:0]) : y1_q;
        y2_d    = st == S4 ? p2[RW-1:0] : y2_q;
        ovf_d   = go ? 1'b0 :
                  st == S4 ? (|(p1 >> RW)) | (|(p2 >> RW)) | (acc_q & acc_sum[RW]) : ovf_q;
    end

    // datapath registers, cleared asynchronously
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r1_q  <= '0;
            r2_q  <= '0;
            r3_q  <= '0;
            b_q   <= '0;
            d_q   <= '0;
            e_q   <= '0;
            acc_q <= 1'b0;
            y1_q  <= '0;
            y2_q  <= '0;
            ovf_q <= 1'b0;
        end else begin
            r1_q  <= r1_d;
            r2_q  <= r2_d;
            r3_q  <= r3_d;
            b_q   <= b_d;
            d_q   <= d_d;
            e_q   <= e_d;
            acc_q <= acc_d;
            y1_q  <= y1_d;
            y2_q  <= y2_d;
            ovf_q <= ovf_d;
        end
    end

    assign y1    = y1_q;
    assign y2    = y2_q;
    assign ovf   = ovf_q;
    assign state = st;
endmodule

// File: tb/tb_fsmd_sched_dp.sv
// tb_fsmd_sched_dp: random and directed jobs against a job-level reference model
module tb_fsmd_sched_dp;
    localparam int W = 4;
    logic         clock = 0, reset = 1, start = 0, acc = 0;
    logic [W-1:0] a = 0, b = 0, c = 0, d = 0, e = 0;
    logic         busy_a, done_a, ovf_a, busy_b, done_b, ovf_b;
    logic [10:0]  y1_a, y2_a;
    logic [7:0]   y1_b, y2_b;
    logic [2:0]   state_a, state_b;
    int           checks = 0, errors = 0, busy_cnt = 0, done_cnt = 0;
    bit           chk_en = 0;
    int           phase = 0;
    longint       my1[2], my2[2];
    bit           movf[2];
    longint       oa, ob, oc, od, oe;
    bit           oacc;
    int           rwv[2] = '{11, 8};

    fsmd_sched_dp #(.WIDTH(W), .RW(11)) dut_a (
        .clock(clock), .reset(reset), .start(start), .acc(acc),
        .a(a), .b(b), .c(c), .d(d), .e(e),
        .busy(busy_a), .done(done_a), .y1(y1_a), .y2(y2_a), .ovf(ovf_a), .state(state_a));

    fsmd_sched_dp #(.WIDTH(W), .RW(8)) dut_b (
        .clock(clock), .reset(reset), .start(start), .acc(acc),
        .a(a), .b(b), .c(c), .d(d), .e(e),
        .busy(busy_b), .done(done_b), .y1(y1_b), .y2(y2_b), .ovf(ovf_b), .state(state_b));

    always #5 clock = ~clock;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s act=%0d exp=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // job-level model: a job occupies five cycles after acceptance and results land at the end
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            phase = 0;
            for (int i = 0; i < 2; i++) begin
                my1[i] = 0; my2[i] = 0; movf[i] = 0;
            end
        end else if (phase == 0) begin
            if (start) begin
                phase = 1;
                oa = a; ob = b; oc = c; od = d; oe = e; oacc = acc;
                movf[0] = 0; movf[1] = 0;
            end
        end else if (phase < 5) begin
            if (phase == 4) begin
                for (int i = 0; i < 2; i++) begin
                    longint s, p1, p2, m;
                    s  = oa + ob + oc;
                    p1 = s * oe;
                    p2 = s * (oc + od);
                    m  = 64'd1 << rwv[i];
                    movf[i] = p1 >= m || p2 >= m || (oacc && my1[i] + p1 % m >= m);
                    my1[i]  = oacc ? (my1[i] + p1) % m : p1 % m;
                    my2[i]  = p2 % m;
                end
            end
            phase++;
        end else begin
            phase = 0;
        end
    end

    // every-cycle comparison of both instances against the model
    always @(negedge clock) begin
        if (chk_en) begin
            busy_cnt += int'(busy_a);
            done_cnt += int'(done_a);
            chk("busy_a", busy_a, phase != 0);
            chk("done_a", done_a, phase == 5);
            chk("state_a", state_a, phase);
            chk("y1_a", y1_a, my1[0]);
            chk("y2_a", y2_a, my2[0]);
            chk("ovf_a", ovf_a, movf[0]);
            chk("busy_b", busy_b, phase != 0);
            chk("done_b", done_b, phase == 5);
            chk("state_b", state_b, phase);
            chk("y1_b", y1_b, my1[1]);
            chk("y2_b", y2_b, my2[1]);
            chk("ovf_b", ovf_b, movf[1]);
        end
    end

    task automatic job(input logic [W-1:0] ia, ib, ic, id, ie, input logic iacc);
        a = ia; b = ib; c = ic; d = id; e = ie; acc = iacc; start = 1;
        @(posedge clock);
        #1 start = 0;
        repeat (6) @(posedge clock);
        #1;
    endtask

    initial begin
        #1 reset = 0;
        chk_en = 1;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_y1", y1_a, 0);
        chk("rst_state", state_a, 0);
        reset = 1;
        @(posedge clock);
        #1;
        busy_cnt = 0; done_cnt = 0;
        job(3, 2, 1, 4, 7, 0);
        chk("j1_y1", y1_a, 42);
        chk("j1_y2", y2_a, 30);
        chk("j1_ovf", ovf_a, 0);
        chk("j1_busy_cycles", busy_cnt, 5);
        chk("j1_done_cycles", done_cnt, 1);
        job(15, 15, 15, 15, 15, 0);
        chk("max_y1", y1_a, 675);
        chk("max_y2", y2_a, 1350);
        chk("max_ovf", ovf_a, 0);
        chk("rw8_y1", y1_b, 163);
        chk("rw8_y2", y2_b, 70);
        chk("rw8_ovf", ovf_b, 1);
        job(3, 2, 1, 4, 7, 0);
        job(3, 2, 1, 4, 7, 1);
        chk("acc_y1", y1_a, 84);
        chk("acc_y2", y2_a, 30);
        done_cnt = 0;
        start = 1;
        for (int i = 0; i < 30; i++) begin
            @(posedge clock);
            #1;
            a = W'($urandom); b = W'($urandom); c = W'($urandom);
            d = W'($urandom); e = W'($urandom); acc = 1'($urandom);
        end
        start = 0;
        chk("held_done_pulses", done_cnt, 5);
        repeat (7) @(posedge clock);
        #1;
        for (int n = 0; n < 40; n++) begin
            a = W'($urandom); b = W'($urandom); c = W'($urandom);
            d = W'($urandom); e = W'($urandom); acc = 1'($urandom);
            start = 1;
            repeat ($urandom_range(1, 3)) begin
                @(posedge clock);
                #1;
                a = W'($urandom); b = W'($urandom); e = W'($urandom);
            end
            start = 0;
            repeat ($urandom_range(0, 6)) @(posedge clock);
            #1;
        end
        repeat (7) @(posedge clock);
        #1;
        a = 3; b = 2; c = 1; d = 4; e = 7; acc = 0; start = 1;
        @(posedge clock);
        #1 start = 0;
        @(posedge clock);
        @(posedge clock);
        #2;
        chk("pre_rst_state", state_a, 3);
        done_cnt = 0;
        reset = 0;
        #1;
        chk("arst_state", state_a, 0);
        chk("arst_busy", busy_a, 0);
        chk("arst_y1", y1_a, 0);
        chk("arst_y2", y2_a, 0);
        chk("arst_ovf", ovf_a, 0);
        repeat (3) @(posedge clock);
        #1 reset = 1;
        chk("arst_no_done", done_cnt, 0);
        job(3, 2, 1, 4, 7, 0);
        chk("post_rst_y1", y1_a, 42);
        chk("post_rst_y2", y2_a, 30);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
